// File: rtl/nand_pipe_arbiter_pkg.sv
// Shared definitions for the NAND pipeline arbiter: status codes,
// statistics counter width and the id-width helper.
package nand_pipe_arbiter_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    localparam int CNT_W = 8;

    // ceil(log2(n)), never below 1 so a 2-requester id is still 1 bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/nand_pipe_arbiter_if.sv
// Requester and response handshake bundle of the NAND pipeline arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface nand_pipe_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 1,
    parameter int IDW     = nand_pipe_arbiter_pkg::clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic [IDW-1:0]           rsp_id;
    logic                     rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/nand_pipe_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest valid index at or above ptr,
// otherwise lowest valid index overall (wrap-around).
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx
);

    logic [IDW-1:0] lo_idx, hi_idx;
    logic           lo_hit, hi_hit;

    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (valid[j]) begin
                lo_idx = IDW'(j);
                lo_hit = 1'b1;
                if (IDW'(j) >= ptr) begin
                    hi_idx = IDW'(j);
                    hi_hit = 1'b1;
                end
            end
        end
    end

    assign idx = hi_hit ? hi_idx : lo_idx;

    always_comb begin
        grant = '0;
        for (int j = 0; j < NUM_REQ; j++)
            grant[j] = lo_hit && (idx == IDW'(j));
    end

endmodule

// File: rtl/nand_pipe_arbiter.sv
// Round-robin sequencer for a shared two-register NAND pipeline.
// Optional NAND_PIPE_ARBITER_STATS_EN adds grant_cnt and stall_cnt.
module nand_pipe_arbiter
    import nand_pipe_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 1
) (
    input  logic clk,
    input  logic rst,
    nand_pipe_arbiter_if.slave bus,
    output logic busy
`ifdef NAND_PIPE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0]         stall_cnt
`endif
);

    localparam int IDW = clog2(NUM_REQ);

    logic               adv, accept;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gidx, rr_ptr, ptr_nxt;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               s1_valid, s2_valid;
    logic [WIDTH-1:0]   s1_a, s1_b, s2_data;
    logic [IDW-1:0]     s1_id, s2_id;
    logic [1:0]         state, state_nxt;
    logic               n1, n2;

    // rst gating keeps req_ready low for the whole reset window
    assign adv = !rst && (!s2_valid || bus.rsp_ready);

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .valid (bus.req_valid & {NUM_REQ{adv}}),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gidx)
    );

    assign accept        = |gnt;
    assign bus.req_ready = gnt;
    assign ptr_nxt = (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + IDW'(1);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = bus.req_a[i*WIDTH +: WIDTH];
                sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        n1 = adv ? accept : s1_valid;
        n2 = adv ? s1_valid : s2_valid;
        state_nxt = RUN;
        unique case (1'b1)
            (!n1 && !n2):           state_nxt = IDLE;
            (n2 && !bus.rsp_ready): state_nxt = STALL;
            default:                state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
            rr_ptr   <= '0;
            state    <= IDLE;
        end else begin
            state <= state_nxt;
            if (adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= ~(s1_a & s1_b);
                    s2_id   <= s1_id;
                end
                s1_valid <= accept;
                if (accept) begin
                    s1_a   <= sel_a;
                    s1_b   <= sel_b;
                    s1_id  <= gidx;
                    rr_ptr <= ptr_nxt;
                end
            end
        end
    end

    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_data  = s2_data;
    assign bus.rsp_id    = s2_id;
    assign busy          = (state != IDLE);

`ifdef NAND_PIPE_ARBITER_STATS_EN
    logic [CNT_W-1:0] gcnt [NUM_REQ];
    logic [CNT_W-1:0] scnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) gcnt[i] <= '0;
            scnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (gnt[i] && gcnt[i] != '1)
                    gcnt[i] <= gcnt[i] + CNT_W'(1);
            if (state == STALL && scnt != '1)
                scnt <= scnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = gcnt[g];
    end
    assign stall_cnt = scnt;
`endif

endmodule
